muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
// - Iterative RV32M execute-stage unit. Consumes operands and funct3 from the decode/issue stage.
// - Computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU with a shift-add / restoring-divide datapath.
// - Result goes back to register-file writeback. Core holds the instruction while busy is high.
// PARAMETERS
// - XLEN  32  operand/result width; iteration count equals XLEN
// PORTS
// - clk     in   1     system clock; all state updates on the rising edge
// - reset   in   1     synchronous, active-high; clears all state
// - start   in   1     request; accepted only when ready=1
// - funct3  in   3     000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
// - rs1     in   XLEN  operand A (dividend / multiplicand)
// - rs2     in   XLEN  operand B (divisor / multiplier)
// - flush   in   1     abandon the in-flight operation (pipeline redirect)
// - ready   out  1     unit idle; a start is accepted this cycle
// - busy    out  1     operation in flight
// - valid   out  1     one-cycle pulse; result is valid this cycle
// - result  out  XLEN  result; held stable from valid until the next accept
// BEHAVIOUR
// - Reset: state=IDLE; ready=1, busy=0, valid=0, result=0. Internal accumulators are cleared.
// - FSM: IDLE -> CALC -> FIX -> DONE -> IDLE.
//   - IDLE: start=1 latches funct3 and operand magnitudes plus the sign flags.
//     - Sign flags: DIV/REM and MULH use both operands signed.
//     - MULHSU: rs1 signed, rs2 unsigned. All other ops unsigned.
//   - CALC: one bit per cycle for exactly XLEN cycles; an iteration counter runs 0..XLEN-1.
//     - Multiply: 2*XLEN-bit unsigned shift-add.
//     - Divide: restoring division, one quotient bit per cycle.
//   - FIX: conditional two's-complement negation, then select.
//     - MUL takes the low XLEN bits; MULH* take the high XLEN bits.
//     - Quotient sign = sA^sB; remainder sign = sA.
//   - DONE: valid=1 for one cycle with result registered, then IDLE.
// - Latency: start high in cycle 0 (accepted) -> valid high in cycle XLEN+2 (cycle 34 for XLEN=32).
// - ready = (state==IDLE). busy is high from cycle 1 through the valid cycle.
// - start while not IDLE is ignored and never queued. Caller must hold inputs only in the accept cycle.
// - Divide by zero: skip CALC, go IDLE->FIX->DONE, valid in cycle 2.
//   - DIV/DIVU quotient = all ones; REM/REMU = rs1.
// - Signed overflow (rs1 = 0x80000000, rs2 = -1, DIV/REM): skip CALC, valid in cycle 2.
//   - Quotient = 0x80000000; remainder = 0.
// - Multiply and all other divides always take the full XLEN iterations (no early-out).
// - flush in any non-IDLE state: return to IDLE next edge, no valid pulse, result unchanged.
//   - flush in IDLE has no effect.
//   - flush together with start in IDLE: flush wins and the start is dropped.
// - reset mid-operation: same as flush, and also clears result to 0.
// - valid and ready are never high in the same cycle; the next start is accepted the cycle after valid.
// - All arithmetic is modulo 2^XLEN except the internal 2*XLEN product.
// TESTING
// - MUL 7*6 -> valid in cycle 34, result=42. MULH 0xFFFFFFFF*0xFFFFFFFF (signed -1*-1) -> result=0.
// - MULHU 0xFFFFFFFF*0xFFFFFFFF -> result=0xFFFFFFFE. MULHSU -1*2 -> result=0xFFFFFFFF.
// - DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); DIVU 100/7 -> 14; REMU 100/7 -> 2.
// - DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, both valid in cycle 2.
//   DIV 0x80000000/-1 -> 0x80000000, valid in cycle 2.
// - start again in cycle 10 of a busy op -> ignored; flush in cycle 10 -> no valid, ready=1 in cycle 11.
// - reset asserted in cycle 20 of a DIV -> cycle 21: ready=1, result=0, no valid.
//   A back-to-back MUL issued right after valid -> accepted, second valid arrives 34 cycles later.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// ---------------------------------------------------------------------------
// muldiv_unit_if : issue/writeback handshake bundle for the RV32M unit
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            flush;
  logic            ready;
  logic            busy;
  logic            valid;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, rs1, rs2, flush,
    input  ready, busy, valid, result
  );

  modport slave (
    input  start, funct3, rs1, rs2, flush,
    output ready, busy, valid, result
  );
endinterface

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit : iterative RV32M multiply/divide (shift-add, restoring divide)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_unit_if.slave  bus
);

  localparam int              CW      = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            sa_q, sa_d;
  logic            sb_q, sb_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [XLEN-1:0] result_q, result_d;

  // Operand decode for the accept cycle
  logic            a_signed, b_signed, in_sa, in_sb;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            is_div, div_zero, div_ovf;

  assign is_div   = bus.funct3[2];
  assign a_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                    (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
  assign b_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                    (bus.funct3 == 3'b110);
  assign in_sa    = a_signed && bus.rs1[XLEN-1];
  assign in_sb    = b_signed && bus.rs2[XLEN-1];
  assign mag_a    = in_sa ? (~bus.rs1 + 1'b1) : bus.rs1;
  assign mag_b    = in_sb ? (~bus.rs2 + 1'b1) : bus.rs2;
  assign div_zero = is_div && (bus.rs2 == '0);
  assign div_ovf  = is_div && !bus.funct3[0] && (bus.rs1 == MIN_NEG) && (bus.rs2 == '1);

  // One iteration of each datapath; {hi,lo} is the product or {remainder,quotient}
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic            div_ge;
  logic [XLEN-1:0] div_rem;

  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
  assign div_shift = {hi_q, lo_q[XLEN-1]};
  assign div_ge    = (div_shift >= {1'b0, opb_q});
  assign div_rem   = div_shift[XLEN-1:0] - opb_q;

  // Sign fix-up and result select
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

  assign prod_fix = (sa_q ^ sb_q) ? (~{hi_q, lo_q} + 1'b1) : {hi_q, lo_q};
  assign quo_fix  = (sa_q ^ sb_q) ? (~lo_q + 1'b1) : lo_q;
  assign rem_fix  = sa_q ? (~hi_q + 1'b1) : hi_q;

  always_comb begin
    fix_res = prod_fix[XLEN-1:0];
    case (op_q)
      3'b000:                 fix_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = quo_fix;
      default:                fix_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          op_d  = bus.funct3;
          cnt_d = '0;
          hi_d  = '0;
          if (div_zero) begin
            // Preload the architected answers; cleared signs make FIX a pass-through
            hi_d    = bus.rs1;
            lo_d    = '1;
            sa_d    = 1'b0;
            sb_d    = 1'b0;
            state_d = S_FIX;
          end else if (div_ovf) begin
            lo_d    = MIN_NEG;
            sa_d    = 1'b0;
            sb_d    = 1'b0;
            state_d = S_FIX;
          end else begin
            sa_d    = in_sa;
            sb_d    = in_sb;
            lo_d    = is_div ? mag_a : mag_b;
            opb_d   = is_div ? mag_b : mag_a;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (!op_q[2]) begin
          hi_d = mul_sum[XLEN:1];
          lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end else begin
          hi_d = div_ge ? div_rem : div_shift[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], div_ge};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        result_d = fix_res;
        state_d  = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (bus.flush && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      result_q <= result_d;
    end
  end

  assign bus.ready  = (state_q == S_IDLE);
  assign bus.busy   = (state_q != S_IDLE);
  assign bus.valid  = (state_q == S_DONE);
  assign bus.result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit : directed self-checking bench for muldiv_unit
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_muldiv_unit;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  muldiv_unit_if #(.XLEN(32)) mdu_if ();

  muldiv_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mdu_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives a request in the current cycle (cycle 0); returns in cycle 1
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    mdu_if.start  = 1'b1;
    mdu_if.funct3 = f3;
    mdu_if.rs1    = a;
    mdu_if.rs2    = b;
    @(posedge clk); #1;
    mdu_if.start  = 1'b0;
    mdu_if.rs1    = '0;
    mdu_if.rs2    = '0;
  endtask

  task automatic wait_valid(inout int cyc);
    while (!mdu_if.valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // Full op: checks latency, result, handshake, then steps to the cycle after valid
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int cyc;
    check({tag, "_ready_c0"}, {31'd0, mdu_if.ready}, 32'd1);
    issue(f3, a, b);
    cyc = 1;
    check({tag, "_busy_c1"}, {31'd0, mdu_if.busy}, 32'd1);
    wait_valid(cyc);
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_result"}, mdu_if.result, exp);
    check({tag, "_ready_at_valid"}, {31'd0, mdu_if.ready}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_ready_after"}, {31'd0, mdu_if.ready}, 32'd1);
    check({tag, "_valid_after"}, {31'd0, mdu_if.valid}, 32'd0);
  endtask

  task automatic count_valids(input int ncyc, output int nv);
    nv = 0;
    for (int i = 0; i < ncyc; i++) begin
      if (mdu_if.valid) nv++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int cyc;
    int nv;
    n_cmp = 0;
    n_err = 0;
    reset         = 1'b1;
    mdu_if.start  = 1'b0;
    mdu_if.flush  = 1'b0;
    mdu_if.funct3 = 3'b000;
    mdu_if.rs1    = '0;
    mdu_if.rs2    = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst_ready",  {31'd0, mdu_if.ready}, 32'd1);
    check("rst_busy",   {31'd0, mdu_if.busy},  32'd0);
    check("rst_valid",  {31'd0, mdu_if.valid}, 32'd0);
    check("rst_result", mdu_if.result, 32'd0);

    run_op("mul",     3'b000, 32'd7,        32'd6,        32'd42,        34);
    run_op("mulh",    3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,         34);
    run_op("mulhu",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE,  34);
    run_op("mulhsu",  3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF,  34);
    run_op("mul_neg", 3'b000, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1,  34);
    run_op("div",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD,  34);
    run_op("rem",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF,  34);
    run_op("divu",    3'b101, 32'd100,      32'd7,        32'd14,        34);
    run_op("remu",    3'b111, 32'd100,      32'd7,        32'd2,         34);
    run_op("divu_z",  3'b101, 32'd5,        32'd0,        32'hFFFFFFFF,  2);
    run_op("rem_z",   3'b110, 32'd5,        32'd0,        32'd5,         2);
    run_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,  2);
    run_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0,         2);

    // A second start while busy is ignored
    issue(3'b000, 32'd3, 32'd5);
    cyc = 1;
    repeat (9) begin @(posedge clk); #1; cyc++; end
    mdu_if.start  = 1'b1;
    mdu_if.funct3 = 3'b101;
    mdu_if.rs1    = 32'd100;
    mdu_if.rs2    = 32'd7;
    @(posedge clk); #1; cyc++;
    mdu_if.start  = 1'b0;
    wait_valid(cyc);
    check("ign_latency", cyc, 34);
    check("ign_result", mdu_if.result, 32'd15);
    @(posedge clk); #1;

    // Flush in cycle 10
    issue(3'b101, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    mdu_if.flush = 1'b1;
    @(posedge clk); #1;
    mdu_if.flush = 1'b0;
    check("flush_ready_c11", {31'd0, mdu_if.ready}, 32'd1);
    check("flush_busy_c11",  {31'd0, mdu_if.busy},  32'd0);
    count_valids(40, nv);
    check("flush_no_valid", nv, 0);
    check("flush_result_kept", mdu_if.result, 32'd15);

    // Flush together with start in IDLE drops the start
    mdu_if.start  = 1'b1;
    mdu_if.flush  = 1'b1;
    mdu_if.funct3 = 3'b000;
    mdu_if.rs1    = 32'd9;
    mdu_if.rs2    = 32'd9;
    @(posedge clk); #1;
    mdu_if.start  = 1'b0;
    mdu_if.flush  = 1'b0;
    check("flstart_ready", {31'd0, mdu_if.ready}, 32'd1);
    count_valids(40, nv);
    check("flstart_no_valid", nv, 0);

    // Reset in cycle 20 of a DIV
    issue(3'b100, 32'd100, 32'd7);
    repeat (19) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rstmid_ready",  {31'd0, mdu_if.ready}, 32'd1);
    check("rstmid_result", mdu_if.result, 32'd0);
    check("rstmid_valid",  {31'd0, mdu_if.valid}, 32'd0);
    count_valids(40, nv);
    check("rstmid_no_valid", nv, 0);

    // Back-to-back: second op issued the cycle after the first valid
    run_op("b2b_divu", 3'b101, 32'd50,    32'd5,    32'd10,     34);
    run_op("b2b_mul",  3'b000, 32'h10000, 32'h10000, 32'h0,     34);
    run_op("b2b_mulu", 3'b011, 32'h10000, 32'h10000, 32'h1,     34);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
